// File: rtl/m_w_stage_pkg.sv
// Shared definitions for the M/W stage: memory access type codes, writeback
// select codes, byte-enable patterns, the memory FSM state type and small
// decode helpers for the access size.
package m_w_stage_pkg;

  // MEM_TYPE codes (access size / sign). Any other code behaves as a word.
  localparam logic [2:0] MT_WORD  = 3'd0;  // LW / SW
  localparam logic [2:0] MT_HALF  = 3'd1;  // LH / SH
  localparam logic [2:0] MT_HALFU = 3'd2;  // LHU
  localparam logic [2:0] MT_BYTE  = 3'd3;  // LB / SB
  localparam logic [2:0] MT_BYTEU = 3'd4;  // LBU

  // MEM_TO_REG writeback select codes.
  localparam logic [1:0] MTR_ALU_OUT = 2'd0;
  localparam logic [1:0] MTR_MEM_OUT = 2'd1;
  localparam logic [1:0] MTR_PC_8    = 2'd2;

  // Byte-enable patterns (bit 0 = bits 7:0, little-endian).
  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  // Data-memory access FSM.
  typedef enum logic {
    MS_IDLE = 1'b0,
    MS_WAIT = 1'b1
  } ms_state_t;

  function automatic logic is_half(input logic [2:0] t);
    return (t == MT_HALF) || (t == MT_HALFU);
  endfunction

  function automatic logic is_byte(input logic [2:0] t);
    return (t == MT_BYTE) || (t == MT_BYTEU);
  endfunction

endpackage

// File: rtl/m_w_stage_load_ext.sv
// load_ext: selects the addressed half/byte of a read word and sign- or
// zero-extends it according to the load type.
//   rdata    in  32  word returned by data memory
//   addr     in  2   byte offset within the word
//   mem_type in  3   MEM_TYPE code of the load
//   data     out 32  extended load value
module load_ext
  import m_w_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  mem_type,
  output logic [31:0] data
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    case (addr)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase

    case (mem_type)
      MT_HALF:  data = {{16{half_sel[15]}}, half_sel};
      MT_HALFU: data = {16'h0000, half_sel};
      MT_BYTE:  data = {{24{byte_sel[7]}}, byte_sel};
      MT_BYTEU: data = {24'h000000, byte_sel};
      default:  data = rdata;
    endcase
  end

endmodule

// File: rtl/m_w_stage.sv
// m_w_stage: memory-access stage and M/W pipeline register.
// Drives a variable-latency data memory (req/ready), builds store byte
// enables and lane-replicated write data, extends load data, stalls the
// upstream pipeline while an access is outstanding and registers the
// instruction into W.
//   clk, reset            clock (rising edge), async active-high reset
//   VALID_M .. WRITE_REG_M  M-stage instruction fields
//   DMEM_*                data-memory port
//   STALL_M               freeze PC/F/D/E/M registers
//   ADDR_EXC_M, BUS_ERR_M one-cycle misalign / timeout pulses
//   *_W                   registered writeback fields
module m_w_stage
  import m_w_stage_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        VALID_M,
  input  logic [31:0] PCadd4M,
  input  logic [31:0] ALU_OUT_M,
  input  logic [31:0] WRITE_DATA_M,
  input  logic        MEM_READ_M,
  input  logic        MEM_WRITE_M,
  input  logic [2:0]  MEM_TYPE_M,
  input  logic [1:0]  MEM_TO_REG_M,
  input  logic        REG_WRITE_M,
  input  logic [4:0]  WRITE_REG_M,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic [31:0] DMEM_ADDR,
  output logic [31:0] DMEM_WDATA,
  output logic [3:0]  DMEM_BE,
  input  logic [31:0] DMEM_RDATA,
  input  logic        DMEM_READY,
  output logic        STALL_M,
  output logic        ADDR_EXC_M,
  output logic        BUS_ERR_M,
  output logic [31:0] PCadd4W,
  output logic [31:0] ALU_OUT_W,
  output logic [31:0] MEM_OUT_W,
  output logic [1:0]  MEM_TO_REG_W,
  output logic        REG_WRITE_W,
  output logic [4:0]  WRITE_REG_W
);

  localparam int unsigned CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  ms_state_t   state, state_next;
  logic [CW-1:0] cnt, cnt_next;

  logic        access, is_load, is_store, size_half, size_byte, misaligned;
  logic        timeout, req_raw, stall_raw, done, pass;
  logic [1:0]  addr_lo;
  logic [31:0] ext_data;

  load_ext u_load_ext (
    .rdata    (DMEM_RDATA),
    .addr     (ALU_OUT_M[1:0]),
    .mem_type (MEM_TYPE_M),
    .data     (ext_data)
  );

  always_comb begin
    addr_lo    = ALU_OUT_M[1:0];
    size_half  = is_half(MEM_TYPE_M);
    size_byte  = is_byte(MEM_TYPE_M);
    access     = VALID_M & (MEM_READ_M | MEM_WRITE_M);
    is_load    = MEM_READ_M;
    is_store   = MEM_WRITE_M & ~MEM_READ_M;
    misaligned = size_byte ? 1'b0 : (size_half ? addr_lo[0] : (addr_lo != 2'b00));

    // The timeout slot is the cycle after MAX_WAIT stalled WAIT cycles: the
    // request is withdrawn, but a ready seen in that cycle still completes.
    timeout = (state == MS_WAIT) && (cnt == CW'(MAX_WAIT));

    if (state == MS_IDLE) req_raw = access & ~misaligned;
    else                  req_raw = ~timeout;

    done      = ((state == MS_WAIT) | req_raw) & DMEM_READY;
    stall_raw = req_raw & ~DMEM_READY;
    // W takes the real instruction only when nothing is pending for it.
    pass      = ((state == MS_IDLE) & ~access) | done;

    state_next = state;
    case (state)
      MS_IDLE: if (req_raw && !DMEM_READY) state_next = MS_WAIT;
      MS_WAIT: if (DMEM_READY || timeout)  state_next = MS_IDLE;
      default: state_next = MS_IDLE;
    endcase
    cnt_next = ((state == MS_WAIT) && (state_next == MS_WAIT)) ? cnt + CW'(1) : '0;
  end

  // Store lanes; loads always request the full word.
  always_comb begin
    DMEM_ADDR = {ALU_OUT_M[31:2], 2'b00};
    if (size_byte) begin
      DMEM_WDATA = {4{WRITE_DATA_M[7:0]}};
      DMEM_BE    = is_store ? (BE_BYTE0 << addr_lo) : BE_WORD;
    end else if (size_half) begin
      DMEM_WDATA = {2{WRITE_DATA_M[15:0]}};
      DMEM_BE    = is_store ? (addr_lo[1] ? BE_HALF_HI : BE_HALF_LO) : BE_WORD;
    end else begin
      DMEM_WDATA = WRITE_DATA_M;
      DMEM_BE    = BE_WORD;
    end
  end

  assign DMEM_REQ   = req_raw & ~reset;
  assign DMEM_WE    = DMEM_REQ & is_store;
  assign STALL_M    = stall_raw & ~reset;
  assign ADDR_EXC_M = (state == MS_IDLE) & access & misaligned & ~reset;
  assign BUS_ERR_M  = timeout & ~DMEM_READY & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= MS_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PCadd4W      <= '0;
      ALU_OUT_W    <= '0;
      MEM_OUT_W    <= '0;
      MEM_TO_REG_W <= MTR_ALU_OUT;
      REG_WRITE_W  <= 1'b0;
      WRITE_REG_W  <= '0;
    end else if (pass) begin
      PCadd4W      <= PCadd4M;
      ALU_OUT_W    <= ALU_OUT_M;
      MEM_OUT_W    <= (access & is_load) ? ext_data : '0;
      MEM_TO_REG_W <= MEM_TO_REG_M;
      REG_WRITE_W  <= REG_WRITE_M & VALID_M;
      WRITE_REG_W  <= WRITE_REG_M;
    end else begin
      PCadd4W      <= '0;
      ALU_OUT_W    <= '0;
      MEM_OUT_W    <= '0;
      MEM_TO_REG_W <= MTR_ALU_OUT;
      REG_WRITE_W  <= 1'b0;
      WRITE_REG_W  <= '0;
    end
  end

endmodule

// File: tb/tb_m_w_stage.sv
// Directed bench for m_w_stage. Each step drives the M inputs, checks the
// memory-port outputs mid-cycle, then pops the expected W contents from a
// scoreboard after the clock edge.
module tb_m_w_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        VALID_M;
  logic [31:0] PCadd4M, ALU_OUT_M, WRITE_DATA_M;
  logic        MEM_READ_M, MEM_WRITE_M;
  logic [2:0]  MEM_TYPE_M;
  logic [1:0]  MEM_TO_REG_M;
  logic        REG_WRITE_M;
  logic [4:0]  WRITE_REG_M;
  logic        DMEM_REQ, DMEM_WE;
  logic [31:0] DMEM_ADDR, DMEM_WDATA;
  logic [3:0]  DMEM_BE;
  logic [31:0] DMEM_RDATA;
  logic        DMEM_READY;
  logic        STALL_M, ADDR_EXC_M, BUS_ERR_M;
  logic [31:0] PCadd4W, ALU_OUT_W, MEM_OUT_W;
  logic [1:0]  MEM_TO_REG_W;
  logic        REG_WRITE_W;
  logic [4:0]  WRITE_REG_W;

  m_w_stage #(.MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset), .VALID_M(VALID_M), .PCadd4M(PCadd4M),
    .ALU_OUT_M(ALU_OUT_M), .WRITE_DATA_M(WRITE_DATA_M),
    .MEM_READ_M(MEM_READ_M), .MEM_WRITE_M(MEM_WRITE_M),
    .MEM_TYPE_M(MEM_TYPE_M), .MEM_TO_REG_M(MEM_TO_REG_M),
    .REG_WRITE_M(REG_WRITE_M), .WRITE_REG_M(WRITE_REG_M),
    .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
    .DMEM_WDATA(DMEM_WDATA), .DMEM_BE(DMEM_BE), .DMEM_RDATA(DMEM_RDATA),
    .DMEM_READY(DMEM_READY), .STALL_M(STALL_M), .ADDR_EXC_M(ADDR_EXC_M),
    .BUS_ERR_M(BUS_ERR_M), .PCadd4W(PCadd4W), .ALU_OUT_W(ALU_OUT_W),
    .MEM_OUT_W(MEM_OUT_W), .MEM_TO_REG_W(MEM_TO_REG_W),
    .REG_WRITE_W(REG_WRITE_W), .WRITE_REG_W(WRITE_REG_W)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, alu, mem;
    logic        rw;
    logic [4:0]  wr;
    logic [1:0]  mtr;
    bit          full;
  } wexp_t;

  wexp_t       sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [31:0] pcv = 32'h0000_0400;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rd, input logic wrm, input logic [2:0] mt,
                       input logic [31:0] alu, input logic [31:0] wd, input logic rw,
                       input logic [4:0] wreg, input logic [1:0] mtr);
    pcv          = pcv + 32'd4;
    VALID_M      = v;
    PCadd4M      = pcv;
    ALU_OUT_M    = alu;
    WRITE_DATA_M = wd;
    MEM_READ_M   = rd;
    MEM_WRITE_M  = wrm;
    MEM_TYPE_M   = mt;
    REG_WRITE_M  = rw;
    WRITE_REG_M  = wreg;
    MEM_TO_REG_M = mtr;
  endtask

  task automatic push_full(input logic [31:0] mem);
    wexp_t e;
    e.pc = pcv; e.alu = ALU_OUT_M; e.mem = mem;
    e.rw = REG_WRITE_M & VALID_M; e.wr = WRITE_REG_M; e.mtr = MEM_TO_REG_M; e.full = 1'b1;
    sb.push_back(e);
  endtask

  task automatic push_bubble();
    wexp_t e;
    e.pc = '0; e.alu = '0; e.mem = '0; e.rw = 1'b0; e.wr = '0; e.mtr = 2'd0; e.full = 1'b0;
    sb.push_back(e);
  endtask

  // One clock cycle: mid-cycle port checks, then the W register after the edge.
  task automatic step(input string tag, input logic e_req, input logic e_stall,
                      input logic e_aexc, input logic e_berr, input bit chk_bus,
                      input logic [3:0] e_be, input logic [31:0] e_wd, input logic e_we,
                      input logic [31:0] e_addr);
    wexp_t e;
    @(negedge clk);
    check({tag, ".req"},   {31'd0, DMEM_REQ},   {31'd0, e_req});
    check({tag, ".stall"}, {31'd0, STALL_M},    {31'd0, e_stall});
    check({tag, ".aexc"},  {31'd0, ADDR_EXC_M}, {31'd0, e_aexc});
    check({tag, ".berr"},  {31'd0, BUS_ERR_M},  {31'd0, e_berr});
    if (chk_bus) begin
      check({tag, ".be"},    {28'd0, DMEM_BE}, {28'd0, e_be});
      check({tag, ".wdata"}, DMEM_WDATA, e_wd);
      check({tag, ".we"},    {31'd0, DMEM_WE}, {31'd0, e_we});
      check({tag, ".addr"},  DMEM_ADDR, e_addr);
    end
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, ".rw_w"},  {31'd0, REG_WRITE_W},  {31'd0, e.rw});
      check({tag, ".wr_w"},  {27'd0, WRITE_REG_W},  {27'd0, e.wr});
      check({tag, ".mtr_w"}, {30'd0, MEM_TO_REG_W}, {30'd0, e.mtr});
      if (e.full) begin
        check({tag, ".pc_w"},  PCadd4W,   e.pc);
        check({tag, ".alu_w"}, ALU_OUT_W, e.alu);
        check({tag, ".mem_w"}, MEM_OUT_W, e.mem);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    DMEM_RDATA = '0;
    DMEM_READY = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'd0, '0, '0, 1'b0, 5'd0, 2'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst.req",   {31'd0, DMEM_REQ},    32'd0);
    check("rst.stall", {31'd0, STALL_M},     32'd0);
    check("rst.rw_w",  {31'd0, REG_WRITE_W}, 32'd0);
    check("rst.alu_w", ALU_OUT_W, 32'd0);
    check("rst.mem_w", MEM_OUT_W, 32'd0);
    reset = 1'b0;

    // ALU op, no memory access
    drive(1'b1, 1'b0, 1'b0, 3'd0, 32'h1234, 32'h0, 1'b1, 5'd5, 2'd0);
    push_full(32'h0);
    step("alu", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0);

    // LB / LBU with immediate ready
    DMEM_RDATA = 32'h80FF_0011;
    DMEM_READY = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 3'd3, 32'h103, 32'h0, 1'b1, 5'd8, 2'd1);
    push_full(32'hFFFF_FF80);
    step("lb", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1111, 32'h0, 1'b0, 32'h100);
    drive(1'b1, 1'b1, 1'b0, 3'd4, 32'h103, 32'h0, 1'b1, 5'd9, 2'd1);
    push_full(32'h0000_0080);
    step("lbu", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0);

    // SB with immediate ready: byte lane 1
    drive(1'b1, 1'b0, 1'b1, 3'd3, 32'h201, 32'h0000_00AB, 1'b0, 5'd0, 2'd0);
    push_full(32'h0);
    step("sb", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010, 32'hABAB_ABAB, 1'b1, 32'h200);

    // SH at 0x202, ready on the fourth request cycle
    DMEM_READY = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 3'd1, 32'h202, 32'hABCD_1234, 1'b0, 5'd0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      push_bubble();
      step($sformatf("sh_stall%0d", i), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
           4'b1100, 32'h1234_1234, 1'b1, 32'h200);
    end
    DMEM_READY = 1'b1;
    push_full(32'h0);
    step("sh_done", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1100, 32'h1234_1234, 1'b1, 32'h200);
    DMEM_READY = 1'b0;

    // Misaligned LW
    drive(1'b1, 1'b1, 1'b0, 3'd0, 32'h102, 32'h0, 1'b1, 5'd7, 2'd1);
    push_bubble();
    step("lw_mis", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0);

    // Load with VALID_M low: no request, no register write
    drive(1'b0, 1'b1, 1'b0, 3'd0, 32'h300, 32'h0, 1'b1, 5'd4, 2'd1);
    push_full(32'h0);
    step("inval", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0);

    // Timeout: request cycle + 4 WAIT cycles stalled, then bus-error slot
    drive(1'b1, 1'b1, 1'b0, 3'd0, 32'h100, 32'h0, 1'b1, 5'd3, 2'd1);
    for (int i = 0; i < 5; i++) begin
      push_bubble();
      step($sformatf("to_wait%0d", i), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0);
    end
    push_bubble();
    step("to_err", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 3'd0, 32'h55, 32'h0, 1'b1, 5'd6, 2'd0);
    push_full(32'h0);
    step("to_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0);

    // Reset during WAIT cycle 2
    drive(1'b1, 1'b1, 1'b0, 3'd0, 32'h200, 32'h0, 1'b1, 5'd2, 2'd1);
    push_bubble();
    step("rw_idle", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0);
    push_bubble();
    step("rw_wait1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0);
    reset = 1'b1;
    #1;
    check("rw_rst.req",   {31'd0, DMEM_REQ},    32'd0);
    check("rw_rst.stall", {31'd0, STALL_M},     32'd0);
    check("rw_rst.rw_w",  {31'd0, REG_WRITE_W}, 32'd0);
    check("rw_rst.pc_w",  PCadd4W, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    DMEM_RDATA = 32'h0000_8001;
    DMEM_READY = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 3'd1, 32'h0, 32'h0, 1'b1, 5'd9, 2'd1);
    push_full(32'hFFFF_8001);
    step("lh_after_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1111, 32'h0, 1'b0, 32'h0);

    check("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
